// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - retiring-instruction handshake bus into the writeback stage
interface writeback_stage_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      inValid;
    logic                      inReady;
    logic                      inRegWrite;
    logic                      inIsLoad;
    logic [REG_ADDR_WIDTH-1:0] inRd;
    logic [31:0]               inResult;
    logic [2:0]                inFunct3;
    logic [1:0]                inAddrLow;

    modport master (
        output inValid, inRegWrite, inIsLoad, inRd, inResult, inFunct3, inAddrLow,
        input  inReady
    );

    modport slave (
        input  inValid, inRegWrite, inIsLoad, inRd, inResult, inFunct3, inAddrLow,
        output inReady
    );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback stage: load align/extend, register file write port, retire counter
// Optional misaligned load trap enabled by defining WB_MISALIGN_TRAP_EN.
module writeback_stage #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    writeback_stage_if.slave          up,
    input  logic                      memRespValid,
    input  logic [31:0]               memRespData,
    output logic                      writeEnable,
    output logic [REG_ADDR_WIDTH-1:0] writeAddress,
    output logic [31:0]               writeData,
`ifdef WB_MISALIGN_TRAP_EN
    output logic                      misalignTrap,
`endif
    output logic [COUNT_WIDTH-1:0]    retireCount
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t                    state;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      reg_write_q;
    logic [2:0]                funct3_q;
    logic [1:0]                addr_low_q;

    logic        accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        misaligned;

    assign up.inReady = (state != WAIT_MEM);
    assign accept     = up.inValid && up.inReady;

    always_comb begin
        byte_sel = memRespData[7:0];
        case (addr_low_q)
            2'd1:    byte_sel = memRespData[15:8];
            2'd2:    byte_sel = memRespData[23:16];
            2'd3:    byte_sel = memRespData[31:24];
            default: byte_sel = memRespData[7:0];
        endcase
        // Halfword select ignores addrLow[0]: misaligned halves read aligned down.
        half_sel = addr_low_q[1] ? memRespData[31:16] : memRespData[15:0];

        load_data = memRespData;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = memRespData;
        endcase

`ifdef WB_MISALIGN_TRAP_EN
        case (funct3_q)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = addr_low_q[0];
            default:        misaligned = (addr_low_q != 2'd0);
        endcase
`else
        misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            funct3_q     <= 3'd0;
            addr_low_q   <= 2'd0;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            writeData    <= 32'd0;
            retireCount  <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            misalignTrap <= 1'b0;
`endif
        end else begin
            writeEnable <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            misalignTrap <= 1'b0;
`endif
            case (state)
                IDLE, WRITE: begin
                    if (accept) begin
                        if (up.inIsLoad) begin
                            rd_q        <= up.inRd;
                            reg_write_q <= up.inRegWrite;
                            funct3_q    <= up.inFunct3;
                            addr_low_q  <= up.inAddrLow;
                            state       <= WAIT_MEM;
                        end else begin
                            // Non-loads drive the write port straight away so they retire next cycle.
                            writeAddress <= up.inRd;
                            writeData    <= up.inResult;
                            writeEnable  <= up.inRegWrite && (up.inRd != '0);
                            retireCount  <= retireCount + COUNT_WIDTH'(1);
                            state        <= WRITE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (memRespValid) begin
                        writeAddress <= rd_q;
                        writeData    <= load_data;
                        writeEnable  <= reg_write_q && (rd_q != '0) && !misaligned;
`ifdef WB_MISALIGN_TRAP_EN
                        misalignTrap <= misaligned;
`endif
                        retireCount  <= retireCount + COUNT_WIDTH'(1);
                        state        <= WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespData = 32'd0;
    logic        writeEnable;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [31:0] retireCount;
`ifdef WB_MISALIGN_TRAP_EN
    logic        misalignTrap;
`endif

    int vectors = 0;
    int miscompares = 0;

    writeback_stage_if #(.REG_ADDR_WIDTH(5)) bus ();

    writeback_stage #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .up           (bus),
        .memRespValid (memRespValid),
        .memRespData  (memRespData),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .writeData    (writeData),
`ifdef WB_MISALIGN_TRAP_EN
        .misalignTrap (misalignTrap),
`endif
        .retireCount  (retireCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic is_load, input logic reg_write, input logic [4:0] rd,
                            input logic [31:0] result, input logic [2:0] funct3, input logic [1:0] addr_low);
        bus.inValid    = 1'b1;
        bus.inIsLoad   = is_load;
        bus.inRegWrite = reg_write;
        bus.inRd       = rd;
        bus.inResult   = result;
        bus.inFunct3   = funct3;
        bus.inAddrLow  = addr_low;
    endtask

    // Accept a load, wait idle_cycles in WAIT_MEM, then answer with data; returns in the WRITE cycle.
    task automatic do_load(input string tag, input logic [2:0] funct3, input logic [1:0] addr_low,
                           input logic [4:0] rd, input logic [31:0] data, input int idle_cycles);
        drive_op(1'b1, 1'b1, rd, 32'h0, funct3, addr_low);
        tick();
        bus.inValid = 1'b0;
        for (int i = 0; i < idle_cycles; i++) begin
            check({tag, "_wait_ready"}, {31'd0, bus.inReady}, 32'd0);
            check({tag, "_wait_we"}, {31'd0, writeEnable}, 32'd0);
            tick();
        end
        memRespValid = 1'b1;
        memRespData  = data;
        tick();
        memRespValid = 1'b0;
    endtask

    initial begin
        drive_op(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        bus.inValid = 1'b0;
        tick();
        check("rst_we", {31'd0, writeEnable}, 32'd0);
        check("rst_wa", {27'd0, writeAddress}, 32'd0);
        check("rst_wd", writeData, 32'd0);
        check("rst_rc", retireCount, 32'd0);
        check("rst_ready", {31'd0, bus.inReady}, 32'd1);
        reset = 1'b0;
        tick();

        // Single non-load
        drive_op(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 2'd0);
        tick();
        bus.inValid = 1'b0;
        check("nl_we", {31'd0, writeEnable}, 32'd1);
        check("nl_wa", {27'd0, writeAddress}, 32'd5);
        check("nl_wd", writeData, 32'hDEADBEEF);
        check("nl_rc", retireCount, 32'd1);

        // Back-to-back non-loads
        for (int i = 1; i <= 3; i++) begin
            drive_op(1'b0, 1'b1, 5'(i), 32'(i * 32'h11), 3'd0, 2'd0);
            check("b2b_ready", {31'd0, bus.inReady}, 32'd1);
            tick();
            check("b2b_we", {31'd0, writeEnable}, 32'd1);
            check("b2b_wa", {27'd0, writeAddress}, 32'(i));
            check("b2b_wd", writeData, 32'(i * 32'h11));
        end
        bus.inValid = 1'b0;
        check("b2b_rc", retireCount, 32'd4);
        tick();
        check("idle_we", {31'd0, writeEnable}, 32'd0);
        check("idle_wa_hold", {27'd0, writeAddress}, 32'd3);
        check("idle_wd_hold", writeData, 32'h33);

        // LB, LBU, LH with sign/zero extension
        do_load("lb", 3'b000, 2'd2, 5'd7, 32'h0080FF00, 3);
        check("lb_we", {31'd0, writeEnable}, 32'd1);
        check("lb_wa", {27'd0, writeAddress}, 32'd7);
        check("lb_wd", writeData, 32'hFFFFFF80);
        check("lb_rc", retireCount, 32'd5);
        check("lb_ready", {31'd0, bus.inReady}, 32'd1);
        do_load("lbu", 3'b100, 2'd2, 5'd7, 32'h0080FF00, 3);
        check("lbu_wd", writeData, 32'h00000080);
        check("lbu_rc", retireCount, 32'd6);
        do_load("lh", 3'b001, 2'd2, 5'd8, 32'h80017FFF, 1);
        check("lh_wd", writeData, 32'hFFFF8001);
        do_load("lhu", 3'b101, 2'd0, 5'd8, 32'h80017FFF, 0);
        check("lhu_wd", writeData, 32'h00007FFF);
        check("lhu_rc", retireCount, 32'd8);

        // rd=0 retires without writing
        drive_op(1'b0, 1'b1, 5'd0, 32'h1234, 3'd0, 2'd0);
        tick();
        bus.inValid = 1'b0;
        check("rd0_we", {31'd0, writeEnable}, 32'd0);
        check("rd0_rc", retireCount, 32'd9);
        tick();
        memRespValid = 1'b1;
        memRespData  = 32'hFFFFFFFF;
        tick();
        memRespValid = 1'b0;
        check("stray_resp_we", {31'd0, writeEnable}, 32'd0);
        check("stray_resp_rc", retireCount, 32'd9);
        tick();
        check("stray_resp_ready", {31'd0, bus.inReady}, 32'd1);

        // Reset while waiting for memory
        drive_op(1'b1, 1'b1, 5'd4, 32'h0, 3'b010, 2'd0);
        tick();
        bus.inValid = 1'b0;
        check("rstwait_ready", {31'd0, bus.inReady}, 32'd0);
        reset = 1'b1;
        #1;
        check("rstwait_async_ready", {31'd0, bus.inReady}, 32'd1);
        check("rstwait_async_rc", retireCount, 32'd0);
        tick();
        reset        = 1'b0;
        memRespValid = 1'b1;
        memRespData  = 32'h5555AAAA;
        tick();
        memRespValid = 1'b0;
        check("rstwait_we", {31'd0, writeEnable}, 32'd0);
        check("rstwait_rc", retireCount, 32'd0);
        check("rstwait_ready2", {31'd0, bus.inReady}, 32'd1);

        // Misaligned word load
        do_load("lw_mis", 3'b010, 2'd1, 5'd9, 32'hCAFEF00D, 1);
        check("lw_mis_rc", retireCount, 32'd1);
`ifdef WB_MISALIGN_TRAP_EN
        check("lw_mis_we", {31'd0, writeEnable}, 32'd0);
        check("lw_mis_trap", {31'd0, misalignTrap}, 32'd1);
        tick();
        check("lw_mis_trap_clear", {31'd0, misalignTrap}, 32'd0);
`else
        check("lw_mis_we", {31'd0, writeEnable}, 32'd1);
        check("lw_mis_wa", {27'd0, writeAddress}, 32'd9);
        check("lw_mis_wd", writeData, 32'hCAFEF00D);
        tick();
`endif
        check("final_we", {31'd0, writeEnable}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
